// File: rtl/cpu_pkg.sv
// Shared types and constants for the MIPS bus CPU.
package cpu_pkg;

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    FETCH = 3'd1,
    EXEC1 = 3'd2,
    EXEC2 = 3'd3,
    HALT  = 3'd4
  } seq_state_t;

  localparam logic [31:0] RESET_VECTOR      = 32'hBFC0_0000;
  localparam logic [31:0] HALT_ADDR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: FETCH / EXEC1 / EXEC2 with
// waitrequest stalls, halt on fetch from HALT_ADDR, retire counter.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] HALT_ADDR = HALT_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        waitrequest,
  input  logic [31:0] pc_value,
  input  logic        instr_is_load,
  input  logic        instr_is_store,
  input  logic        instr_writes_rf,
  output logic        mem_read,
  output logic        mem_write,
  output logic        addr_sel,
  output logic        ir_wen,
  output logic        pc_wen,
  output logic        rf_wen,
  output logic        active,
  output logic [2:0]  state_o,
  output logic [31:0] instr_count
);

  seq_state_t  state_q, state_d;
  logic [31:0] count_q, count_d;
  logic        mem_op;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr_sel  = 1'b0;
    ir_wen    = 1'b0;
    pc_wen    = 1'b0;
    rf_wen    = 1'b0;
    mem_op    = 1'b0;
    unique case (state_q)
      // INIT masks the transient 0 the PC shows right after reset
      INIT: state_d = FETCH;
      FETCH: begin
        if (pc_value == HALT_ADDR) begin
          state_d = HALT;
        end else begin
          mem_read = 1'b1;
          if (!waitrequest) begin
            ir_wen  = 1'b1;
            state_d = EXEC1;
          end
        end
      end
      EXEC1: begin
        mem_op = instr_is_load | instr_is_store;
        if (mem_op) begin
          addr_sel  = 1'b1;
          mem_read  = instr_is_load;
          mem_write = instr_is_store & ~instr_is_load;
        end
        if (!mem_op || !waitrequest) begin
          pc_wen = 1'b1;
          if (instr_is_load) begin
            state_d = EXEC2;
          end else begin
            rf_wen  = instr_writes_rf;
            count_d = count_q + 32'd1;
            state_d = FETCH;
          end
        end
      end
      EXEC2: begin
        rf_wen  = 1'b1;
        count_d = count_q + 32'd1;
        state_d = FETCH;
      end
      HALT: state_d = HALT;
      default: state_d = INIT;
    endcase
  end

  assign active      = (state_q != HALT);
  assign state_o     = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer with a small PC-block model.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  typedef struct packed {
    logic [9:0]  ov;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        waitrequest;
  logic [31:0] pc_value;
  logic        instr_is_load;
  logic        instr_is_store;
  logic        instr_writes_rf;
  logic        mem_read, mem_write, addr_sel;
  logic        ir_wen, pc_wen, rf_wen, active;
  logic [2:0]  state_o;
  logic [31:0] instr_count;

  logic        started;
  logic        jmp_en;
  logic [31:0] jmp_tgt;
  logic [9:0]  obs;
  logic [31:0] ecnt;
  exp_t        sb[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  cpu_sequencer #(.HALT_ADDR(HALT_ADDR_DEFAULT)) dut (
    .clk(clk),
    .reset(reset),
    .waitrequest(waitrequest),
    .pc_value(pc_value),
    .instr_is_load(instr_is_load),
    .instr_is_store(instr_is_store),
    .instr_writes_rf(instr_writes_rf),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .addr_sel(addr_sel),
    .ir_wen(ir_wen),
    .pc_wen(pc_wen),
    .rf_wen(rf_wen),
    .active(active),
    .state_o(state_o),
    .instr_count(instr_count)
  );

  // PC block: 0 during reset, reset vector one edge later
  always @(posedge clk) begin
    if (reset) begin
      pc_value <= 32'h0;
      started  <= 1'b0;
    end else if (!started) begin
      pc_value <= RESET_VECTOR;
      started  <= 1'b1;
    end else if (pc_wen) begin
      pc_value <= jmp_en ? jmp_tgt : pc_value + 32'd4;
    end
  end

  assign obs = {state_o, mem_read, mem_write, addr_sel,
                ir_wen, pc_wen, rf_wen, active};

  function automatic exp_t ex(input logic [2:0] s,
                              input bit mr, mw, as, ir, pw, rw, act,
                              input logic [31:0] c);
    ex.ov  = {s, mr, mw, as, ir, pw, rw, act};
    ex.cnt = c;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({obs, instr_count} !== {ex(INIT, 0,0,0,0,0,0,1, 32'd0)}) begin
        errors++;
        $display("FAIL reset[%0d] got %h/%0d exp INIT idle cnt 0",
                 i, obs, instr_count);
      end
    end
    reset = 1'b0;
    ecnt  = 32'd0;
    @(negedge clk);
    checks++;
    if (state_o !== INIT || active !== 1'b1) begin
      errors++;
      $display("FAIL init_cycle got state %0d active %b exp 0/1",
               state_o, active);
    end
    @(posedge clk); #1;
    checks++;
    if (state_o !== FETCH || pc_value !== RESET_VECTOR) begin
      errors++;
      $display("FAIL first_fetch got state %0d pc %h exp 1/%h",
               state_o, pc_value, RESET_VECTOR);
    end
  endtask

  task automatic test_alu();
    instr_is_load = 0; instr_is_store = 0; instr_writes_rf = 1;
    sb.push_back(ex(FETCH, 1,0,0,1,0,0,1, ecnt));
    sb.push_back(ex(EXEC1, 0,0,0,0,1,1,1, ecnt));
    for (int i = 0; i < 2; i++) begin
      waitrequest = 1'b0;
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({obs, instr_count} !== e) begin
        errors++;
        $display("FAIL alu[%0d] got %h/%0d exp %h/%0d",
                 i, obs, instr_count, e.ov, e.cnt);
      end
      @(posedge clk); #1;
    end
    ecnt++;
    checks++;
    if (instr_count !== ecnt) begin
      errors++;
      $display("FAIL alu_count got %0d exp %0d", instr_count, ecnt);
    end
  endtask

  task automatic test_load_wait();
    logic [6:0]  wv;
    logic [31:0] pc0;
    wv  = 7'b0011011;
    pc0 = pc_value;
    instr_is_load = 1; instr_is_store = 0; instr_writes_rf = 1;
    sb.push_back(ex(FETCH, 1,0,0,0,0,0,1, ecnt));
    sb.push_back(ex(FETCH, 1,0,0,0,0,0,1, ecnt));
    sb.push_back(ex(FETCH, 1,0,0,1,0,0,1, ecnt));
    sb.push_back(ex(EXEC1, 1,0,1,0,0,0,1, ecnt));
    sb.push_back(ex(EXEC1, 1,0,1,0,0,0,1, ecnt));
    sb.push_back(ex(EXEC1, 1,0,1,0,1,0,1, ecnt));
    sb.push_back(ex(EXEC2, 0,0,0,0,0,1,1, ecnt));
    for (int i = 0; i < 7; i++) begin
      waitrequest = wv[i];
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({obs, instr_count} !== e) begin
        errors++;
        $display("FAIL load[%0d] got %h/%0d exp %h/%0d",
                 i, obs, instr_count, e.ov, e.cnt);
      end
      @(posedge clk); #1;
    end
    waitrequest = 1'b0;
    ecnt++;
    checks++;
    if (instr_count !== ecnt || pc_value !== pc0 + 32'd4) begin
      errors++;
      $display("FAIL load_done got cnt %0d pc %h exp %0d/%h",
               instr_count, pc_value, ecnt, pc0 + 32'd4);
    end
  endtask

  task automatic test_store();
    logic [2:0] wv;
    wv = 3'b010;
    instr_is_load = 0; instr_is_store = 1; instr_writes_rf = 0;
    sb.push_back(ex(FETCH, 1,0,0,1,0,0,1, ecnt));
    sb.push_back(ex(EXEC1, 0,1,1,0,0,0,1, ecnt));
    sb.push_back(ex(EXEC1, 0,1,1,0,1,0,1, ecnt));
    for (int i = 0; i < 3; i++) begin
      waitrequest = wv[i];
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({obs, instr_count} !== e) begin
        errors++;
        $display("FAIL store[%0d] got %h/%0d exp %h/%0d",
                 i, obs, instr_count, e.ov, e.cnt);
      end
      @(posedge clk); #1;
    end
    waitrequest = 1'b0;
    ecnt++;
  endtask

  task automatic test_back_to_back();
    logic [2:0]  wrf;
    logic [31:0] c;
    wrf = 3'b101;
    c   = ecnt;
    instr_is_load = 0; instr_is_store = 0;
    for (int k = 0; k < 3; k++) begin
      sb.push_back(ex(FETCH, 1,0,0,1,0,0,1, c));
      sb.push_back(ex(EXEC1, 0,0,0,0,1,wrf[k],1, c));
      c++;
    end
    for (int i = 0; i < 6; i++) begin
      waitrequest     = 1'b0;
      instr_writes_rf = wrf[i/2];
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({obs, instr_count} !== e) begin
        errors++;
        $display("FAIL b2b[%0d] got %h/%0d exp %h/%0d",
                 i, obs, instr_count, e.ov, e.cnt);
      end
      @(posedge clk); #1;
    end
    ecnt = c;
  endtask

  task automatic test_halt();
    logic [31:0] c;
    c = ecnt;
    instr_is_load = 0; instr_is_store = 0;
    sb.push_back(ex(FETCH, 1,0,0,1,0,0,1, c));
    sb.push_back(ex(EXEC1, 0,0,0,0,1,0,1, c));
    sb.push_back(ex(FETCH, 1,0,0,1,0,0,1, c + 1));
    sb.push_back(ex(EXEC1, 0,0,0,0,1,1,1, c + 1));
    sb.push_back(ex(FETCH, 0,0,0,0,0,0,1, c + 2));
    for (int k = 0; k < 20; k++)
      sb.push_back(ex(HALT, 0,0,0,0,0,0,0, c + 2));
    for (int i = 0; i < 25; i++) begin
      instr_writes_rf = (i >= 2);
      if (i == 2) begin
        jmp_en  = 1'b1;
        jmp_tgt = HALT_ADDR_DEFAULT;
      end
      waitrequest = (i < 4) ? 1'b0 : 1'($urandom_range(0, 1));
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({obs, instr_count} !== e) begin
        errors++;
        $display("FAIL halt[%0d] got %h/%0d exp %h/%0d",
                 i, obs, instr_count, e.ov, e.cnt);
      end
      @(posedge clk); #1;
    end
    jmp_en      = 1'b0;
    waitrequest = 1'b0;
    ecnt        = c + 2;
  endtask

  task automatic test_reset_stall();
    logic [2:0] wv;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    ecnt = 32'd0;
    checks++;
    if (state_o !== FETCH || pc_value !== RESET_VECTOR ||
        instr_count !== 32'd0) begin
      errors++;
      $display("FAIL restart got state %0d pc %h cnt %0d exp 1/%h/0",
               state_o, pc_value, instr_count, RESET_VECTOR);
    end
    wv = 3'b110;
    instr_is_load = 1; instr_is_store = 0; instr_writes_rf = 1;
    sb.push_back(ex(FETCH, 1,0,0,1,0,0,1, ecnt));
    sb.push_back(ex(EXEC1, 1,0,1,0,0,0,1, ecnt));
    sb.push_back(ex(EXEC1, 1,0,1,0,0,0,1, ecnt));
    for (int i = 0; i < 3; i++) begin
      waitrequest = wv[i];
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({obs, instr_count} !== e) begin
        errors++;
        $display("FAIL stall[%0d] got %h/%0d exp %h/%0d",
                 i, obs, instr_count, e.ov, e.cnt);
      end
      if (i < 2) begin
        @(posedge clk); #1;
      end
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({obs, instr_count} !== {ex(INIT, 0,0,0,0,0,0,1, 32'd0)}) begin
      errors++;
      $display("FAIL stall_reset got %h/%0d exp INIT idle cnt 0",
               obs, instr_count);
    end
    reset = 1'b0; waitrequest = 1'b0; instr_is_load = 0;
    @(posedge clk); #1;
    checks++;
    if (state_o !== FETCH || pc_value !== RESET_VECTOR) begin
      errors++;
      $display("FAIL stall_restart got state %0d pc %h exp 1/%h",
               state_o, pc_value, RESET_VECTOR);
    end
    test_alu();
  endtask

  initial begin
    reset = 1'b1; waitrequest = 1'b0;
    instr_is_load = 0; instr_is_store = 0; instr_writes_rf = 0;
    jmp_en = 1'b0; jmp_tgt = 32'h0; ecnt = 32'd0;
    test_reset();
    test_alu();
    test_load_wait();
    test_store();
    test_back_to_back();
    test_halt();
    test_reset_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
